cshm_coef_sequencer: RTL and testbench

Drives the select side of the CSHM FIR datapath. It holds the filter coefficients and, for each input sample, decomposes every coefficient into 4-bit nibbles. Each nibble becomes a (select, shift, sign, zero) command for the odd-multiple 8:1 select/shift/accumulate stage. It is the producer of the 3-bit odd-multiple select (0→x1 … 7→x15) that the precomputed-multiple multiplexer consumes, and it sequences the taps under a valid/ready handshake.

---
 rtl/cshm_pkg.sv | 24 ++
 rtl/cshm_nibble_encoder.sv | 34 +++
 rtl/cshm_coef_sequencer.sv | 152 +++++++++++++++
 tb/tb_cshm_coef_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cshm_pkg.sv
// Shared types and constants for the CSHM coefficient sequencer.
package cshm_pkg;

  localparam int NIB_PER_COEF = 4;
  localparam int SEL_W        = 3;
  localparam int SHIFT_W      = 4;
  localparam int TAP_MAX_W    = 6;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // tap is sized for the largest bank (64 taps); smaller banks use the low bits
  typedef struct packed {
    logic [SEL_W-1:0]     sel;
    logic [SHIFT_W-1:0]   shift;
    logic                 neg;
    logic                 zero;
    logic [TAP_MAX_W-1:0] tap;
    logic                 last_nib;
  } cmd_t;

endpackage

// File: rtl/cshm_nibble_encoder.sv
// Splits a 4-bit magnitude nibble into odd * 2^s; sel is the odd-multiple index (odd-1)/2.
module cshm_nibble_encoder
  import cshm_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic             zero,
  output logic [SEL_W-1:0] sel,
  output logic [1:0]       s
);

  // lowest set bit gives the shift; bits above it are the odd multiple without its LSB
  always_comb begin
    zero = (nibble == 4'd0);
    sel  = 3'd0;
    s    = 2'd0;
    if (nibble[0]) begin
      s   = 2'd0;
      sel = nibble[3:1];
    end else if (nibble[1]) begin
      s   = 2'd1;
      sel = {1'b0, nibble[3:2]};
    end else if (nibble[2]) begin
      s   = 2'd2;
      sel = {2'b00, nibble[3]};
    end else if (nibble[3]) begin
      s   = 2'd3;
      sel = 3'd0;
    end else begin
      s   = 2'd0;
      sel = 3'd0;
    end
  end

endmodule

// File: rtl/cshm_coef_sequencer.sv
// Holds FIR coefficients and streams one (select, shift, sign, zero) command per
// coefficient nibble, tap 0 first, under a valid/ready handshake.
module cshm_coef_sequencer
  import cshm_pkg::*;
#(
  parameter int NTAPS  = 8,
  parameter int COEF_W = 16,
  localparam int TAP_W = $clog2(NTAPS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               coef_we,
  input  logic [TAP_W-1:0]   coef_addr,
  input  logic [COEF_W-1:0]  coef_wdata,
  input  logic               sample_start,
  output logic               busy,
  output logic               cmd_valid,
  input  logic               cmd_ready,
  output logic [SEL_W-1:0]   cmd_sel,
  output logic [SHIFT_W-1:0] cmd_shift,
  output logic               cmd_neg,
  output logic               cmd_zero,
  output logic [TAP_W-1:0]   cmd_tap,
  output logic               cmd_last_nib,
  output logic               frame_done
);

  state_e             state_r, state_s;
  logic [TAP_W-1:0]   tap_r, tap_s;
  logic [1:0]         nib_r, nib_s;
  logic               final_s;
  logic               bank_we_s;
  logic [COEF_W-1:0]  bank_r [NTAPS];
  logic [COEF_W-1:0]  coef_rd_s;
  logic [COEF_W-1:0]  mag_s;
  logic [3:0]         nibble_s;
  logic               enc_zero_s;
  logic [SEL_W-1:0]   enc_sel_s;
  logic [1:0]         enc_s_s;
  cmd_t               cmd_s, cmd_r;
  logic               frame_done_r;
  logic               unused_tap_s;

  assign bank_we_s = coef_we && (state_r == IDLE);

  // coefficient bank, writable only while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NTAPS; i++) bank_r[i] <= '0;
    end else if (bank_we_s) begin
      bank_r[coef_addr] <= coef_wdata;
    end
  end

  // next-state: advance nibble, then tap, on each accepted command
  always_comb begin
    state_s = state_r;
    tap_s   = tap_r;
    nib_s   = nib_r;
    final_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sample_start) begin
          state_s = RUN;
          tap_s   = '0;
          nib_s   = 2'd0;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (cmd_ready) begin
          if (nib_r == 2'(NIB_PER_COEF - 1)) begin
            nib_s = 2'd0;
            if (tap_r == TAP_W'(NTAPS - 1)) begin
              final_s = 1'b1;
              state_s = IDLE;
              tap_s   = '0;
            end else begin
              tap_s = tap_r + TAP_W'(1);
            end
          end else begin
            nib_s = nib_r + 2'd1;
          end
        end else begin
          state_s = RUN;
        end
      end
      default: begin
        state_s = IDLE;
        tap_s   = '0;
        nib_s   = 2'd0;
      end
    endcase
  end

  // forwarding a same-edge write keeps the first tap consistent with the rest of the frame
  assign coef_rd_s = (bank_we_s && (coef_addr == tap_s)) ? coef_wdata : bank_r[tap_s];
  assign mag_s     = coef_rd_s[COEF_W-1] ? (COEF_W'(0) - coef_rd_s) : coef_rd_s;
  assign nibble_s  = mag_s[{nib_s, 2'b00} +: 4];

  cshm_nibble_encoder u_enc (
    .nibble (nibble_s),
    .zero   (enc_zero_s),
    .sel    (enc_sel_s),
    .s      (enc_s_s)
  );

  // command for the position the FSM moves to; stalls recompute the same value
  always_comb begin
    cmd_s = '0;
    if (state_s == RUN) begin
      cmd_s.sel      = enc_sel_s;
      cmd_s.shift    = {nib_s, enc_s_s};
      cmd_s.neg      = coef_rd_s[COEF_W-1];
      cmd_s.zero     = enc_zero_s;
      cmd_s.tap      = TAP_MAX_W'(tap_s);
      cmd_s.last_nib = (nib_s == 2'(NIB_PER_COEF - 1));
    end else begin
      cmd_s = '0;
    end
  end

  // state, position and registered command outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      tap_r        <= '0;
      nib_r        <= 2'd0;
      cmd_r        <= '0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      tap_r        <= tap_s;
      nib_r        <= nib_s;
      cmd_r        <= cmd_s;
      frame_done_r <= final_s;
    end
  end

  assign busy         = (state_r != IDLE);
  assign cmd_valid    = (state_r == RUN);
  assign cmd_sel      = cmd_r.sel;
  assign cmd_shift    = cmd_r.shift;
  assign cmd_neg      = cmd_r.neg;
  assign cmd_zero     = cmd_r.zero;
  assign cmd_tap      = cmd_r.tap[TAP_W-1:0];
  assign cmd_last_nib = cmd_r.last_nib;
  assign frame_done   = frame_done_r;
  assign unused_tap_s = ^cmd_r.tap;

endmodule

// File: tb/tb_cshm_coef_sequencer.sv
// Directed bench for cshm_coef_sequencer: hand-computed per-tap command tables plus
// back-pressure, write-during-run, late-start and mid-frame reset sequences.
module tb_cshm_coef_sequencer;

  localparam int NT = 8;
  localparam int NC = 4 * NT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_wdata;
  logic        sample_start;
  logic        busy;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_sel;
  logic [3:0]  cmd_shift;
  logic        cmd_neg;
  logic        cmd_zero;
  logic [2:0]  cmd_tap;
  logic        cmd_last_nib;
  logic        frame_done;

  cshm_coef_sequencer #(.NTAPS(NT), .COEF_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_wdata(coef_wdata), .sample_start(sample_start), .busy(busy),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
    .cmd_shift(cmd_shift), .cmd_neg(cmd_neg), .cmd_zero(cmd_zero),
    .cmd_tap(cmd_tap), .cmd_last_nib(cmd_last_nib), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0]      coef;
    logic [3:0][2:0]  sel;    // index = nibble
    logic [3:0][3:0]  shift;
    logic [3:0]       zero;
    logic             neg;
  } vec_t;

  vec_t       tab [NT];
  logic [2:0] e_sel   [NC];
  logic [3:0] e_shift [NC];
  logic       e_zero  [NC];
  logic       e_neg   [NC];
  int         chk_cnt  = 0;
  int         pass_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic load_exp(input bit use_tab);
    for (int t = 0; t < NT; t++) begin
      for (int k = 0; k < 4; k++) begin
        e_sel[4*t+k]   = use_tab ? tab[t].sel[k] : 3'd0;
        e_shift[4*t+k] = use_tab ? tab[t].shift[k] : 4'(4 * k);
        e_zero[4*t+k]  = use_tab ? tab[t].zero[k] : 1'b1;
        e_neg[4*t+k]   = use_tab ? tab[t].neg : 1'b0;
      end
    end
  endtask

  task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    coef_we = 1'b1; coef_addr = a; coef_wdata = d;
    @(negedge clk);
    coef_we = 1'b0;
  endtask

  task automatic run_frame(input bit rnd, input int we_at, input int rst_at, input bit start_at_end);
    int         idx = 0;
    int         cyc = 0;
    bit         stalled = 1'b0;
    logic [15:0] held = 16'h0;
    @(negedge clk);
    sample_start = 1'b1;
    @(negedge clk);
    sample_start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
    while (idx < NC && cyc < 600) begin
      chk($sformatf("valid_%0d", idx), 32'(cmd_valid), 32'd1);
      if (stalled)
        chk($sformatf("stall_stable_%0d", idx),
            32'({cmd_sel, cmd_shift, cmd_neg, cmd_zero, cmd_tap, cmd_last_nib}), 32'(held));
      if (rst_at == idx) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(cmd_valid), 32'd0);
        chk("rst_fields", 32'({cmd_sel, cmd_shift, cmd_neg, cmd_zero, cmd_tap, cmd_last_nib}), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cmd_ready = 1'b0;
        for (int i = 0; i < 40; i++) begin
          @(negedge clk);
          if (frame_done !== 1'b0 || busy !== 1'b0)
            chk("post_rst_quiet", 32'({frame_done, busy}), 32'd0);
        end
        chk("post_rst_idle", 32'({frame_done, busy, cmd_valid}), 32'd0);
        return;
      end
      if (we_at == idx) begin
        coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'h1111;
      end
      cmd_ready    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      sample_start = (rnd && (idx % 7 == 3)) || (start_at_end && idx == NC - 1);
      if (cmd_ready) begin
        chk($sformatf("cmd_%0d", idx),
            32'({cmd_sel, cmd_shift, cmd_neg, cmd_zero, cmd_tap, cmd_last_nib}),
            32'({e_sel[idx], e_shift[idx], e_neg[idx], e_zero[idx], 3'(idx / 4), (idx % 4 == 3)}));
        idx++;
        stalled = 1'b0;
      end else begin
        held    = {cmd_sel, cmd_shift, cmd_neg, cmd_zero, cmd_tap, cmd_last_nib};
        stalled = 1'b1;
      end
      @(negedge clk);
      cyc++;
      coef_we = 1'b0;
      sample_start = 1'b0;
    end
    if (idx < NC) chk("frame_timeout", 32'(idx), 32'(NC));
    if (!rnd) chk("frame_cycles", 32'(cyc), 32'(NC));
    chk("done_pulse", 32'({frame_done, cmd_valid, busy}), 32'b100);
    cmd_ready = 1'b0;
    @(negedge clk);
    chk("done_clear", 32'({frame_done, cmd_valid, busy}), 32'b000);
  endtask

  initial begin
    tab[0] = '{coef:16'h0C6F, sel:{3'd0, 3'd1, 3'd1, 3'd7}, shift:{4'd12, 4'd10, 4'd5, 4'd0}, zero:4'b1000, neg:1'b0};
    tab[1] = '{coef:16'hFF58, sel:{3'd0, 3'd0, 3'd2, 3'd0}, shift:{4'd12, 4'd8, 4'd5, 4'd3},  zero:4'b1100, neg:1'b1};
    tab[2] = '{coef:16'h8000, sel:{3'd0, 3'd0, 3'd0, 3'd0}, shift:{4'd15, 4'd8, 4'd4, 4'd0},  zero:4'b0111, neg:1'b1};
    tab[3] = '{coef:16'h7FFF, sel:{3'd3, 3'd7, 3'd7, 3'd7}, shift:{4'd12, 4'd8, 4'd4, 4'd0},  zero:4'b0000, neg:1'b0};
    tab[4] = '{coef:16'hFFFF, sel:{3'd0, 3'd0, 3'd0, 3'd0}, shift:{4'd12, 4'd8, 4'd4, 4'd0},  zero:4'b1110, neg:1'b1};
    tab[5] = '{coef:16'h1234, sel:{3'd0, 3'd0, 3'd1, 3'd0}, shift:{4'd12, 4'd9, 4'd4, 4'd2},  zero:4'b0000, neg:1'b0};
    tab[6] = '{coef:16'hF000, sel:{3'd0, 3'd0, 3'd0, 3'd0}, shift:{4'd12, 4'd8, 4'd4, 4'd0},  zero:4'b0111, neg:1'b1};
    tab[7] = '{coef:16'h0090, sel:{3'd0, 3'd0, 3'd4, 3'd0}, shift:{4'd12, 4'd8, 4'd4, 4'd0},  zero:4'b1101, neg:1'b0};

    rst_n = 1'b0; coef_we = 1'b0; coef_addr = 3'd0; coef_wdata = 16'h0;
    sample_start = 1'b0; cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(cmd_valid), 32'd0);
    chk("reset_done", 32'(frame_done), 32'd0);
    chk("reset_fields", 32'({cmd_sel, cmd_shift, cmd_neg, cmd_zero, cmd_tap, cmd_last_nib}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // all-zero bank, ready held high
    load_exp(1'b0);
    run_frame(1'b0, -1, -1, 1'b0);

    // table coefficients under random back-pressure with stray starts
    for (int t = 0; t < NT; t++) write_coef(3'(t), tab[t].coef);
    load_exp(1'b1);
    run_frame(1'b1, -1, -1, 1'b0);

    // write to tap 0 mid-frame and a start on the final handshake, both ignored
    run_frame(1'b0, 5, -1, 1'b1);
    chk("late_start_ignored", 32'(busy), 32'd0);
    run_frame(1'b0, -1, -1, 1'b0);

    // reset at command 10 clears everything including the bank
    run_frame(1'b0, -1, 10, 1'b0);
    load_exp(1'b0);
    run_frame(1'b0, -1, -1, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
